// File: rtl/vlsu_req_arbiter.sv
// Arbitrates load and store requesters onto the single fragmenter port, one request in flight.
// Loads wait for stores to finish; a starving load forces a store drain.
module vlsu_req_arbiter #(
   parameter int unsigned MaxOutstanding  = 4,
   parameter int unsigned StarvationLimit = 8,
   parameter type         vlsu_req_t      = logic
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       ld_req_valid_i,
   output logic       ld_req_ready_o,
   input  vlsu_req_t  ld_req_i,
   input  logic       st_req_valid_i,
   output logic       st_req_ready_o,
   input  vlsu_req_t  st_req_i,
   output logic       frag_req_valid_o,
   input  logic       frag_req_ready_i,
   output vlsu_req_t  frag_req_o,
   input  logic       done_i,
   input  logic       done_is_load_i,
   output logic [3:0] ld_cnt_o,
   output logic [3:0] st_cnt_o,
   output logic       err_o
);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;

   localparam logic [4:0] MaxOut    = 5'(MaxOutstanding);
   localparam logic [7:0] StarveMax = 8'(StarvationLimit);

   state_e     r_state, w_state_nxt;
   vlsu_req_t  r_req;
   logic       r_is_load, r_rr_ptr, r_err;
   logic [3:0] r_ld_cnt, r_st_cnt;
   logic [7:0] r_starve;

   logic [4:0] w_total;
   logic       w_room, w_starved, w_ld_elig, w_st_elig;
   logic       w_grant_ld, w_grant_st, w_frag_hs;
   logic       w_ld_inc, w_st_inc, w_ld_dec, w_st_dec, w_err_set;

   function automatic logic [3:0] cnt_nxt(input logic [3:0] c, input logic inc, input logic dec);
      if (inc && !dec)              return c + 4'd1;
      else if (dec && !inc && c != 0) return c - 4'd1;
      else                          return c;
   endfunction

   assign w_total   = {1'b0, r_ld_cnt} + {1'b0, r_st_cnt};
   assign w_room    = w_total < MaxOut;
   assign w_starved = (r_starve == StarveMax);
   assign w_ld_elig = ld_req_valid_i && (r_st_cnt == 4'd0) && w_room;
   // Stores are also held off in the IDLE cycle that commits to DRAIN, otherwise a
   // store stream could keep winning and the drain would never start.
   assign w_st_elig = st_req_valid_i && w_room && (r_state == IDLE) && !w_starved;
   assign w_frag_hs = (r_state == ISSUE) && frag_req_ready_i;

   always_comb begin
      w_grant_ld  = 1'b0;
      w_grant_st  = 1'b0;
      w_state_nxt = r_state;
      unique case (r_state)
         IDLE: begin
            if (w_ld_elig && (!w_st_elig || !r_rr_ptr)) w_grant_ld = 1'b1;
            else if (w_st_elig)                         w_grant_st = 1'b1;
            if (w_grant_ld || w_grant_st) w_state_nxt = ISSUE;
            else if (w_starved)           w_state_nxt = DRAIN;
         end
         ISSUE: if (frag_req_ready_i) w_state_nxt = IDLE;
         DRAIN: begin
            if (w_ld_elig) begin
               w_grant_ld  = 1'b1;
               w_state_nxt = ISSUE;
            end else if (!ld_req_valid_i) begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
      if (rst_i) begin
         w_grant_ld = 1'b0;
         w_grant_st = 1'b0;
      end
   end

   assign w_ld_inc  = w_frag_hs && r_is_load;
   assign w_st_inc  = w_frag_hs && !r_is_load;
   assign w_ld_dec  = done_i && done_is_load_i;
   assign w_st_dec  = done_i && !done_is_load_i;
   assign w_err_set = (w_ld_dec && !w_ld_inc && r_ld_cnt == 4'd0) ||
                      (w_st_dec && !w_st_inc && r_st_cnt == 4'd0);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state   <= IDLE;
         r_req     <= '0;
         r_is_load <= 1'b0;
         r_rr_ptr  <= 1'b0;
         r_err     <= 1'b0;
         r_ld_cnt  <= '0;
         r_st_cnt  <= '0;
         r_starve  <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_grant_ld || w_grant_st) begin
            r_req     <= w_grant_ld ? ld_req_i : st_req_i;
            r_is_load <= w_grant_ld;
            r_rr_ptr  <= w_grant_ld;
         end
         // Saturates at the limit; a drain abandoned by the load also forgets the starvation.
         if (w_grant_ld || (r_state == DRAIN && !ld_req_valid_i))
            r_starve <= '0;
         else if (ld_req_valid_i && r_st_cnt != 4'd0 && !w_starved)
            r_starve <= r_starve + 8'd1;
         r_ld_cnt <= cnt_nxt(r_ld_cnt, w_ld_inc, w_ld_dec);
         r_st_cnt <= cnt_nxt(r_st_cnt, w_st_inc, w_st_dec);
         if (w_err_set) r_err <= 1'b1;
      end
   end

   assign ld_req_ready_o   = w_grant_ld;
   assign st_req_ready_o   = w_grant_st;
   assign frag_req_valid_o = (r_state == ISSUE);
   assign frag_req_o       = r_req;
   assign ld_cnt_o         = r_ld_cnt;
   assign st_cnt_o         = r_st_cnt;
   assign err_o            = r_err;

endmodule

// File: tb/tb_vlsu_req_arbiter.sv
// Directed and random stimulus for vlsu_req_arbiter; a scoreboard of granted requests and
// a counter model are checked by a negedge monitor.
module tb_vlsu_req_arbiter;

   localparam int MAXO   = 4;
   localparam int STARVE = 8;

   typedef logic [15:0] req_t;
   typedef struct packed {
      logic is_ld;
      req_t d;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_i = 1'b1;
   logic       ld_req_valid_i = 1'b0, st_req_valid_i = 1'b0;
   logic       ld_req_ready_o, st_req_ready_o;
   req_t       ld_req_i = '0, st_req_i = '0, frag_req_o;
   logic       frag_req_valid_o, frag_req_ready_i = 1'b0;
   logic       done_i = 1'b0, done_is_load_i = 1'b0;
   logic [3:0] ld_cnt_o, st_cnt_o;
   logic       err_o;

   int   n_chk = 0, n_err = 0;
   int   m_ld = 0, m_st = 0, m_err = 0, m_pend = 0;
   exp_t q[$];

   vlsu_req_arbiter #(.MaxOutstanding(MAXO), .StarvationLimit(STARVE), .vlsu_req_t(req_t)) dut (
      .clk_i(clk), .rst_i(rst_i),
      .ld_req_valid_i(ld_req_valid_i), .ld_req_ready_o(ld_req_ready_o), .ld_req_i(ld_req_i),
      .st_req_valid_i(st_req_valid_i), .st_req_ready_o(st_req_ready_o), .st_req_i(st_req_i),
      .frag_req_valid_o(frag_req_valid_o), .frag_req_ready_i(frag_req_ready_i),
      .frag_req_o(frag_req_o), .done_i(done_i), .done_is_load_i(done_is_load_i),
      .ld_cnt_o(ld_cnt_o), .st_cnt_o(st_cnt_o), .err_o(err_o));

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: compares outputs against the model, then advances the model to the next edge.
   always @(negedge clk) begin : mon
      exp_t e;
      int   ldi, sti, ldd, std;
      ldi = 0; sti = 0;
      if (rst_i) begin
         chk("rst_ready", int'(ld_req_ready_o | st_req_ready_o), 0);
         m_ld = 0; m_st = 0; m_err = 0; m_pend = 0;
         q.delete();
      end else begin
         chk("ld_cnt", int'(ld_cnt_o), m_ld);
         chk("st_cnt", int'(st_cnt_o), m_st);
         chk("err", int'(err_o), m_err);
         chk("frag_valid", int'(frag_req_valid_o), m_pend);
         if (ld_req_ready_o || st_req_ready_o) begin
            chk("ready_excl", int'(ld_req_ready_o & st_req_ready_o), 0);
            chk("ready_in_issue", int'(frag_req_valid_o), 0);
         end
         if (ld_req_ready_o)
            chk("ld_grant_legal", int'(ld_req_valid_i && m_st == 0 && m_ld + m_st < MAXO), 1);
         if (st_req_ready_o)
            chk("st_grant_legal", int'(st_req_valid_i && m_ld + m_st < MAXO), 1);
         if (frag_req_valid_o && frag_req_ready_i) begin
            if (q.size() == 0) chk("frag_unexpected", int'(frag_req_valid_o), 0);
            else begin
               e = q.pop_front();
               chk("frag_data", int'(frag_req_o), int'(e.d));
               ldi = int'(e.is_ld);
               sti = int'(!e.is_ld);
            end
            m_pend = 0;
         end
         if (ld_req_ready_o && ld_req_valid_i) begin q.push_back({1'b1, ld_req_i}); m_pend = 1; end
         if (st_req_ready_o && st_req_valid_i) begin q.push_back({1'b0, st_req_i}); m_pend = 1; end
         ldd = int'(done_i && done_is_load_i);
         std = int'(done_i && !done_is_load_i);
         if ((ldd && !ldi && m_ld == 0) || (std && !sti && m_st == 0)) m_err = 1;
         if (ldi && !ldd) m_ld++; else if (ldd && !ldi && m_ld > 0) m_ld--;
         if (sti && !std) m_st++; else if (std && !sti && m_st > 0) m_st--;
      end
   end

   task automatic step(); @(posedge clk); #1; endtask
   task automatic look(); @(negedge clk); #1; endtask

   task automatic do_reset();
      rst_i = 1'b1; step(); step(); rst_i = 1'b0;
   endtask

   task automatic drain_all();
      ld_req_valid_i = 1'b0; st_req_valid_i = 1'b0; frag_req_ready_i = 1'b1; done_i = 1'b0;
      step(); step();
      for (int i = 0; i < 40 && (m_ld + m_st) > 0; i++) begin
         done_i = 1'b1; done_is_load_i = (m_ld > 0);
         step();
      end
      done_i = 1'b0;
      step(); look();
      chk("drain_counts", int'({ld_cnt_o, st_cnt_o}), 0);
      chk("drain_idle", int'(frag_req_valid_o), 0);
      step();
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin : stim
      do_reset();
      look();
      chk("reset_ld_cnt", int'(ld_cnt_o), 0);
      chk("reset_frag_v", int'(frag_req_valid_o), 0);
      chk("reset_err", int'(err_o), 0);
      step();

      // Test 1: lone load, ready at 0, valid at 1, count at 2
      ld_req_valid_i = 1'b1; ld_req_i = 16'hA5A1; frag_req_ready_i = 1'b1;
      look(); chk("t1_ld_ready", int'(ld_req_ready_o), 1);
      step(); ld_req_valid_i = 1'b0;
      look(); chk("t1_frag_valid", int'(frag_req_valid_o), 1);
      chk("t1_frag_data", int'(frag_req_o), 32'hA5A1);
      step(); look(); chk("t1_ld_cnt", int'(ld_cnt_o), 1);
      drain_all();

      // Test 2: both valid from reset, zero-latency completions keep counts at 0
      do_reset();
      ld_req_valid_i = 1'b1; st_req_valid_i = 1'b1; frag_req_ready_i = 1'b1;
      for (int c = 0; c < 8; c++) begin
         ld_req_i = req_t'($urandom); st_req_i = req_t'($urandom);
         done_i = (c % 2 == 1); done_is_load_i = (c % 4 == 1);
         look();
         if (c % 2 == 0) begin
            chk("t2_ld_ready", int'(ld_req_ready_o), int'(c % 4 == 0));
            chk("t2_st_ready", int'(st_req_ready_o), int'(c % 4 == 2));
         end
         step();
      end
      done_i = 1'b0;
      drain_all();

      // Test 3: load starved by an outstanding store enters DRAIN
      do_reset();
      st_req_valid_i = 1'b1; st_req_i = 16'h5701; frag_req_ready_i = 1'b1;
      step(); st_req_valid_i = 1'b0; step(); step();
      ld_req_i = 16'h1D03; st_req_i = 16'h5702;
      for (int k = 0; k < 22; k++) begin
         ld_req_valid_i = 1'b1;
         st_req_valid_i = (k >= STARVE);
         done_i = (k == 20); done_is_load_i = 1'b0;
         look();
         chk("t3_no_st_grant", int'(st_req_ready_o), 0);
         chk("t3_ld_ready", int'(ld_req_ready_o), int'(k == 21));
         step();
      end
      done_i = 1'b0;
      drain_all();

      // Test 4: outstanding limit blocks a waiting store until a completion
      do_reset();
      st_req_valid_i = 1'b1; frag_req_ready_i = 1'b1;
      for (int k = 0; k < 14; k++) begin
         st_req_i = req_t'($urandom);
         done_i = (k == 12); done_is_load_i = 1'b0;
         look();
         if (k >= 8 && k < 13) chk("t4_blocked", int'(st_req_ready_o), 0);
         if (k == 8) chk("t4_st_cnt_full", int'(st_cnt_o), MAXO);
         if (k == 13) chk("t4_grant_after_done", int'(st_req_ready_o), 1);
         step();
      end
      done_i = 1'b0;
      drain_all();

      // Test 5: completion against an empty load counter is sticky until reset
      do_reset();
      done_i = 1'b1; done_is_load_i = 1'b1;
      step(); done_i = 1'b0;
      look(); chk("t5_err", int'(err_o), 1); chk("t5_ld_cnt", int'(ld_cnt_o), 0);
      step(); step(); step();
      look(); chk("t5_err_sticky", int'(err_o), 1);
      step(); do_reset();
      look(); chk("t5_err_cleared", int'(err_o), 0);
      step();

      // Test 6: reset while a request is held in ISSUE
      ld_req_valid_i = 1'b1; ld_req_i = 16'h0C06; frag_req_ready_i = 1'b0;
      step(); ld_req_valid_i = 1'b0;
      look(); chk("t6_issue", int'(frag_req_valid_o), 1);
      step(); rst_i = 1'b1;
      step(); rst_i = 1'b0;
      look(); chk("t6_dropped", int'(frag_req_valid_o), 0);
      chk("t6_counts", int'({ld_cnt_o, st_cnt_o}), 0);
      step(); frag_req_ready_i = 1'b1;
      step(); look(); chk("t6_no_count", int'(ld_cnt_o), 0);
      step();

      // Random traffic
      for (int n = 0; n < 700; n++) begin
         ld_req_valid_i   = ($urandom_range(0, 2) != 0);
         st_req_valid_i   = ($urandom_range(0, 2) != 0);
         ld_req_i         = req_t'($urandom);
         st_req_i         = req_t'($urandom);
         frag_req_ready_i = ($urandom_range(0, 3) != 0);
         done_i = 1'b0;
         if ($urandom_range(0, 2) == 0 && (m_ld + m_st) > 0) begin
            done_i = 1'b1;
            done_is_load_i = (m_ld > 0) && (m_st == 0 || $urandom_range(0, 1) == 1);
         end
         step();
      end
      drain_all();
      chk("final_queue_empty", q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
